// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch unit: defaults, FSM encoding and the IF/ID bundle.
package if_pkg;

  localparam int          XLEN         = 32;
  localparam int          WIN_LSB      = 8;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } ifid_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Program counter: register, +4 adder and redirect/advance selection with word-alignment clamp.
module if_pc_gen
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;

  // Carry out of bit 31 is dropped, so 0xFFFF_FFFC wraps to 0.
  assign w_pc_plus4 = r_pc + PC_STEP;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      r_pc <= align_word(RESET_PC);
    end else if (i_load) begin
      r_pc <= align_word(i_target);
    end else if (i_advance) begin
      r_pc <= w_pc_plus4;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch initiator: drives the ROM address from the PC, runs the START/RUN/HALTED FSM and the IF/ID register.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [23:0] BASE_ADDRESS = 24'd0,
  parameter logic [31:0] NOP_WORD     = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        fetch_fault_o
);

  fetch_state_e r_state;
  ifid_t        r_ifid;
  logic         r_fault;

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic        w_in_window;
  logic        w_tgt_in_window;
  logic        w_tgt_misaligned;
  logic        w_pc_load;
  logic        w_pc_advance;

  assign w_in_window      = (w_pc[31:WIN_LSB] == BASE_ADDRESS);
  assign w_tgt_in_window  = (redirect_pc_i[31:WIN_LSB] == BASE_ADDRESS);
  assign w_tgt_misaligned = |redirect_pc_i[1:0];

  // A halted fetcher only restarts on a redirect that lands back inside the ROM window.
  assign w_pc_load    = redirect_i &
                        ((r_state == ST_RUN) || ((r_state == ST_HALTED) && w_tgt_in_window));
  assign w_pc_advance = (r_state == ST_RUN) && !redirect_i && !stall_i && w_in_window;

  if_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_pc_load),
    .i_advance  (w_pc_advance),
    .i_target   (redirect_pc_i),
    .o_pc       (w_pc),
    .o_pc_plus4 (w_pc_plus4)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_START;
      r_ifid.instr <= NOP_WORD;
      r_ifid.pc    <= '0;
      r_ifid.pc4   <= '0;
      r_ifid.valid <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      case (r_state)
        ST_START: r_state <= ST_RUN;

        ST_RUN: begin
          if (redirect_i) begin
            // Wrong-path word already in IF/ID is squashed.
            r_ifid.instr <= NOP_WORD;
            r_ifid.valid <= 1'b0;
            r_fault      <= w_tgt_misaligned;
          end else if (stall_i) begin
            r_fault <= 1'b0;
            if (flush_i) begin
              r_ifid.instr <= NOP_WORD;
              r_ifid.valid <= 1'b0;
            end
          end else if (!w_in_window) begin
            r_state      <= ST_HALTED;
            r_ifid.instr <= NOP_WORD;
            r_ifid.valid <= 1'b0;
            r_fault      <= 1'b1;
          end else begin
            r_ifid.instr <= flush_i ? NOP_WORD : imem_data_i;
            r_ifid.pc    <= w_pc;
            r_ifid.pc4   <= w_pc_plus4;
            r_ifid.valid <= !flush_i;
            r_fault      <= 1'b0;
          end
        end

        ST_HALTED: begin
          if (redirect_i && w_tgt_in_window) begin
            r_state <= ST_RUN;
            r_fault <= w_tgt_misaligned;
          end
        end

        default: r_state <= ST_START;
      endcase
    end
  end

  assign imem_addr_o   = w_pc;
  assign ifid_instr_o  = r_ifid.instr;
  assign ifid_pc_o     = r_ifid.pc;
  assign ifid_pc4_o    = r_ifid.pc4;
  assign ifid_valid_o  = r_ifid.valid;
  assign fetch_fault_o = r_fault;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random stall/flush/redirect traffic against a behavioural model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [23:0] BASE     = 24'd0;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_i, flush_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic [31:0] ifid_instr_o, ifid_pc_o, ifid_pc4_o;
  logic        ifid_valid_o, fetch_fault_o;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
  logic        m_valid, m_fault, m_started, m_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
  endfunction

  assign imem_data_i = rom_word(imem_addr_o);

  if_fetch_unit #(
    .RESET_PC     (RESET_PC),
    .BASE_ADDRESS (BASE),
    .NOP_WORD     (NOP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .ifid_instr_o  (ifid_instr_o),
    .ifid_pc_o     (ifid_pc_o),
    .ifid_pc4_o    (ifid_pc4_o),
    .ifid_valid_o  (ifid_valid_o),
    .fetch_fault_o (fetch_fault_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = {RESET_PC[31:2], 2'b00};
    m_instr   = NOP;
    m_ipc     = '0;
    m_ipc4    = '0;
    m_valid   = 1'b0;
    m_fault   = 1'b0;
    m_started = 1'b0;
    m_halted  = 1'b0;
  endtask

  // One rising edge of the fetch rules, applied to the model.
  task automatic model_step(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    logic tgt_ok;
    tgt_ok = (tg[31:8] == BASE);
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_halted) begin
      if (rd && tgt_ok) begin
        m_halted = 1'b0;
        m_pc     = tg & 32'hFFFF_FFFC;
        m_fault  = (tg[1:0] != 2'b00);
      end
    end else if (rd) begin
      m_pc    = tg & 32'hFFFF_FFFC;
      m_valid = 1'b0;
      m_instr = NOP;
      m_fault = (tg[1:0] != 2'b00);
    end else if (st) begin
      m_fault = 1'b0;
      if (fl) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end
    end else if (m_pc[31:8] != BASE) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_fault  = 1'b1;
    end else begin
      m_instr = fl ? NOP : rom_word(m_pc);
      m_valid = !fl;
      m_ipc   = m_pc;
      m_ipc4  = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_fault = 1'b0;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".addr"},  imem_addr_o,           m_pc);
    check({where, ".instr"}, ifid_instr_o,          m_instr);
    check({where, ".pc"},    ifid_pc_o,             m_ipc);
    check({where, ".pc4"},   ifid_pc4_o,            m_ipc4);
    check({where, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, m_valid});
    check({where, ".fault"}, {31'd0, fetch_fault_o}, {31'd0, m_fault});
  endtask

  task automatic cycle(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = tg;
    model_step(st, fl, rd, tg);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  // Reset asserted between edges while a redirect is pending; outputs must drop at once.
  task automatic mid_reset(input logic [31:0] tg);
    #2;
    redirect_i    = 1'b1;
    redirect_pc_i = tg;
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    redirect_i = 1'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    logic [31:0] tg;
    int          r;

    reset_n = 1'b0;
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Free-running fetch: first edge leaves START, then one word per edge.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    check("seq_addr", imem_addr_o, 32'h8);
    check("seq_ipc",  ifid_pc_o,   32'h4);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0);
    check("stall_addr", imem_addr_o, 32'h8);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("unstall_ipc", ifid_pc_o, 32'h8);

    cycle(1'b1, 1'b0, 1'b1, 32'h40);
    check("redir_addr",  imem_addr_o,           32'h40);
    check("redir_valid", {31'd0, ifid_valid_o}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    check("redir_ipc",   ifid_pc_o,             32'h40);

    cycle(1'b0, 1'b0, 1'b1, 32'h42);
    check("misal_addr",  imem_addr_o,            32'h40);
    check("misal_fault", {31'd0, fetch_fault_o}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    check("flush_valid", {31'd0, ifid_valid_o}, 32'd0);
    check("flush_addr",  imem_addr_o,           32'h44);

    // Run off the end of the window.
    cycle(1'b0, 1'b0, 1'b1, 32'hF0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0);
    check("halt_addr",  imem_addr_o,            32'h100);
    check("halt_fault", {31'd0, fetch_fault_o}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h200);
    check("halt_oow",   imem_addr_o,            32'h100);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    check("resume_fault", {31'd0, fetch_fault_o}, 32'd0);
    check("resume_addr",  imem_addr_o,            32'h0);
    cycle(1'b0, 1'b0, 1'b0, '0);

    mid_reset(32'h80);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, '0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: tg = {24'd0, 6'($urandom), 2'b00};
        6, 7:             tg = {24'd0, 8'($urandom)};
        8:                tg = $urandom;
        default:          tg = {24'd0, 4'hF, 2'($urandom), 2'b00};
      endcase
      if ($urandom_range(0, 99) == 0) begin
        mid_reset(tg);
      end else begin
        cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
              $urandom_range(0, 6) == 0, tg);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
